// File: rtl/pipe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_pkg : shared FSM encoding and pipeline constants              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hz_state_e;

  // Instruction the pipeline registers load when their bubble bit is set.
  localparam logic [15:0] NOP_INSTR = 16'hB0FF;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_hazard_ctrl_if : hazard requests in, pipeline enables out     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pipe_hazard_ctrl_if #(
  parameter int NUM_STAGES = 5
);
  logic                  branch;
  logic                  load_use;
  logic                  cache_stall;
  logic                  hlt_fetch;
  logic                  pc_en;
  logic [NUM_STAGES-2:0] reg_en;
  logic [NUM_STAGES-2:0] reg_bubble;
  logic                  halted;

  modport master (
    input  branch, load_use, cache_stall, hlt_fetch,
    output pc_en, reg_en, reg_bubble, halted
  );

  modport slave (
    output branch, load_use, cache_stall, hlt_fetch,
    input  pc_en, reg_en, reg_bubble, halted
  );
endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sat_counter : saturating up-counter with synchronous clear         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clear,
  input  wire logic             inc,
  output logic      [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_hazard_ctrl : N-stage hazard/flush/halt-drain controller      |
// | Optional perf counters: define PIPE_HAZARD_PERF_EN. Rev 1.0        |
// +--------------------------------------------------------------------+
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int BR_STAGE   = 2,
  parameter int LU_REG     = 1,
  parameter int CNT_W      = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  pipe_hazard_ctrl_if.master    hz,
  output logic      [CNT_W-1:0] perf_cycles,
  output logic      [CNT_W-1:0] perf_stalls,
  output logic      [CNT_W-1:0] perf_flushes
);

  localparam int            NR      = NUM_STAGES - 1;
  localparam logic [NR-1:0] BR_MASK = NR'((1 << BR_STAGE) - 1);
  localparam logic [NR-1:0] LU_BUB  = NR'(1 << LU_REG);
  localparam logic [NR-1:0] LU_EN   = ~NR'((1 << LU_REG) - 1);

  hz_state_e     state, state_nx;
  logic          flush_pend, flush_pend_nx;
  logic [2:0]    drain_cnt, drain_cnt_nx;
  logic          pc_en, redirect, advance;
  logic [NR-1:0] reg_en, reg_bubble;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_pend <= 1'b0;
      drain_cnt  <= 3'd0;
    end else begin
      state      <= state_nx;
      flush_pend <= flush_pend_nx;
      drain_cnt  <= drain_cnt_nx;
    end
  end

  always_comb begin
    pc_en         = 1'b0;
    reg_en        = '0;
    reg_bubble    = '0;
    redirect      = 1'b0;
    advance       = 1'b0;
    state_nx      = state;
    flush_pend_nx = flush_pend;
    drain_cnt_nx  = drain_cnt;

    if (state == HALTED) begin
      pc_en = 1'b0;
    end else if (hz.cache_stall) begin
      // A branch seen during a freeze is remembered and replayed afterwards.
      if (hz.branch) flush_pend_nx = 1'b1;
    end else if (hz.branch || flush_pend) begin
      redirect      = 1'b1;
      pc_en         = 1'b1;
      reg_en        = '1;
      reg_bubble    = BR_MASK;
      flush_pend_nx = 1'b0;
    end else if (hz.load_use) begin
      reg_en     = LU_EN;
      reg_bubble = LU_BUB;
    end else begin
      pc_en  = 1'b1;
      reg_en = '1;
    end

    advance = reg_en[NR-1];

    case (state)
      RUN: begin
        if (advance && !redirect && hz.hlt_fetch) begin
          state_nx     = DRAIN;
          drain_cnt_nx = 3'(NUM_STAGES - 1);
        end
      end
      DRAIN: begin
        // A redirect proves the halt was on a wrong path: resume fetching.
        if (redirect) begin
          state_nx     = RUN;
          drain_cnt_nx = 3'd0;
        end else begin
          pc_en = 1'b0;
          if (advance) begin
            drain_cnt_nx = drain_cnt - 3'd1;
            if (drain_cnt == 3'd1) state_nx = HALTED;
          end
        end
      end
      default: begin
        state_nx = state;
      end
    endcase
  end

  assign hz.pc_en      = rst_n & pc_en;
  assign hz.reg_en     = rst_n ? reg_en : '0;
  assign hz.reg_bubble = rst_n ? reg_bubble : '0;
  assign hz.halted     = rst_n & (state == HALTED);

`ifdef PIPE_HAZARD_PERF_EN
  sat_counter #(.WIDTH(CNT_W)) u_perf_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (state != HALTED),
    .count (perf_cycles)
  );

  sat_counter #(.WIDTH(CNT_W)) u_perf_stalls (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   ((state == RUN) && !pc_en),
    .count (perf_stalls)
  );

  sat_counter #(.WIDTH(CNT_W)) u_perf_flushes (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (1'b0),
    .inc   (redirect),
    .count (perf_flushes)
  );
`else
  assign perf_cycles  = '0;
  assign perf_stalls  = '0;
  assign perf_flushes = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : directed vectors with queued expectations    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

`ifdef PIPE_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    string       name;
    logic        pc;
    logic [3:0]  en;
    logic [3:0]  bub;
    logic        h;
    bit          chk_perf;
    logic [15:0] cyc;
    logic [15:0] stl;
    logic [15:0] fls;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] perf_cycles, perf_stalls, perf_flushes;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  pipe_hazard_ctrl_if #(.NUM_STAGES(5)) hz();

  pipe_hazard_ctrl #(
    .NUM_STAGES (5),
    .BR_STAGE   (2),
    .LU_REG     (1),
    .CNT_W      (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hz           (hz),
    .perf_cycles  (perf_cycles),
    .perf_stalls  (perf_stalls),
    .perf_flushes (perf_flushes)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, req);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.name, "pc_en", 16'(hz.pc_en), 16'(e.pc));
      cmp(e.name, "reg_en", 16'(hz.reg_en), 16'(e.en));
      cmp(e.name, "reg_bubble", 16'(hz.reg_bubble), 16'(e.bub));
      cmp(e.name, "halted", 16'(hz.halted), 16'(e.h));
      if (e.chk_perf) begin
        cmp(e.name, "perf_cycles", perf_cycles, e.cyc);
        cmp(e.name, "perf_stalls", perf_stalls, e.stl);
        cmp(e.name, "perf_flushes", perf_flushes, e.fls);
      end
    end
  end

  task automatic step(input string nm, input logic rn, input logic br, input logic lu,
                      input logic cs, input logic hf, input logic pc, input logic [3:0] en,
                      input logic [3:0] bub, input logic h, input bit cp = 1'b0,
                      input logic [15:0] cyc = 16'd0, input logic [15:0] stl = 16'd0,
                      input logic [15:0] fls = 16'd0);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n          = rn;
    hz.branch      = br;
    hz.load_use    = lu;
    hz.cache_stall = cs;
    hz.hlt_fetch   = hf;
    e.name     = nm;
    e.pc       = pc;
    e.en       = en;
    e.bub      = bub;
    e.h        = h;
    e.chk_perf = cp;
    e.cyc      = PERF ? cyc : 16'd0;
    e.stl      = PERF ? stl : 16'd0;
    e.fls      = PERF ? fls : 16'd0;
    sb.push_back(e);
  endtask

  initial begin
    hz.branch      = 1'b0;
    hz.load_use    = 1'b0;
    hz.cache_stall = 1'b0;
    hz.hlt_fetch   = 1'b0;

    //       name        rn br lu cs hf  pc  en       bub      h
    step("reset",        0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 1'b1, 0, 0, 0);
    // Ten counted cycles: two load-use stalls and one branch.
    step("lu0",          1, 0, 1, 0, 0,  0, 4'b1110, 4'b0010, 0);
    step("lu0_after",    1, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 0);
    step("br0",          1, 1, 0, 0, 0,  1, 4'b1111, 4'b0011, 0);
    step("br0_after",    1, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 0);
    step("lu1",          1, 0, 1, 0, 0,  0, 4'b1110, 4'b0010, 0);
    for (int i = 0; i < 5; i++)
      step("idle",       1, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 0);
    step("perf10",       1, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 0, 1'b1, 16'd10, 16'd2, 16'd1);

    // Branch during a cache stall is deferred until the stall lifts.
    step("cs_br",        1, 1, 0, 1, 0,  0, 4'b0000, 4'b0000, 0);
    step("cs_hold1",     1, 0, 0, 1, 0,  0, 4'b0000, 4'b0000, 0);
    step("cs_hold2",     1, 0, 0, 1, 0,  0, 4'b0000, 4'b0000, 0);
    step("flush_replay", 1, 0, 0, 0, 0,  1, 4'b1111, 4'b0011, 0);
    step("flush_clear",  1, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 0);
    step("br_lu",        1, 1, 1, 0, 0,  1, 4'b1111, 4'b0011, 0);
    step("hf_br",        1, 1, 0, 0, 1,  1, 4'b1111, 4'b0011, 0);
    step("hf_br_run",    1, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 0);

    // Speculative halt cancelled by a redirect.
    step("spec_hf",      1, 0, 0, 0, 1,  1, 4'b1111, 4'b0000, 0);
    step("spec_d1",      1, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 0);
    step("spec_d2",      1, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 0);
    step("spec_br",      1, 1, 0, 0, 0,  1, 4'b1111, 4'b0011, 0);
    for (int i = 0; i < 5; i++)
      step("spec_run",   1, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 0);

    // Full halt, with a cache stall that pauses the drain count.
    step("halt_hf",      1, 0, 0, 0, 1,  1, 4'b1111, 4'b0000, 0);
    step("drain_cs",     1, 0, 0, 1, 0,  0, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 4; i++)
      step("drain",      1, 0, 0, 0, 0,  0, 4'b1111, 4'b0000, 0);
    step("halted1",      1, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 1);
    step("halted2",      1, 0, 1, 0, 1,  0, 4'b0000, 4'b0000, 1);
    step("halted_br",    1, 1, 0, 0, 0,  0, 4'b0000, 4'b0000, 1);
    step("halt_rst",     0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0);
    step("post_rst",     1, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 0);

    // Reset mid-drain with a flush pending clears everything.
    step("md_hf",        1, 0, 0, 0, 1,  1, 4'b1111, 4'b0000, 0);
    step("md_cs_br",     1, 1, 0, 1, 0,  0, 4'b0000, 4'b0000, 0);
    step("md_rst",       0, 0, 0, 0, 0,  0, 4'b0000, 4'b0000, 0, 1'b1, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      step("md_run",     1, 0, 0, 0, 0,  1, 4'b1111, 4'b0000, 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain_queue: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
